intt_gs_butterfly: RTL

//  Pipelined Gentleman-Sande inverse-NTT butterfly over Z_Q (Q = `Q = 132120577, from params.vh).

---
 rtl/intt_gs_butterfly.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/intt_gs_butterfly.sv
// Pipelined Gentleman-Sande inverse-NTT butterfly over Z_Q, Q = 132120577.
// Produces (a+b) mod Q and ((a-b)*w) mod Q through a fixed nine-stage datapath.
// A credit-guarded show-ahead FIFO on the output provides valid/ready backpressure.
module intt_gs_butterfly #(
  parameter int K     = 27,
  parameter int IDX_W = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K-1:0]     in_a,
  input  logic [K-1:0]     in_b,
  input  logic [K-1:0]     in_w,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K-1:0]     out_a,
  output logic [K-1:0]     out_b,
  output logic [IDX_W-1:0] out_idx
);

  // The Barrett reduction below is hand-built as six register stages, so its
  // latency is fixed by the structure rather than configurable.
  localparam int BARRETT_LAT = 6;
  localparam int LAT         = 3 + BARRETT_LAT;
  localparam int IF_W        = $clog2(LAT + 1);
  localparam int PTR_W       = $clog2(DEPTH);
  localparam int CNT_W       = PTR_W + 1;

  localparam longint unsigned Q_VAL = 64'd132120577;
  localparam logic [K-1:0]    QK    = K'(Q_VAL);
  localparam logic [K:0]      QK1   = (K+1)'(Q_VAL);
  localparam logic [K+1:0]    QK2   = (K+2)'(Q_VAL);
  // Barrett constant floor(2^(2K) / Q); fits in K+1 bits because Q > 2^(K-1).
  localparam logic [K:0]      MU    = (K+1)'((64'd1 << (2*K)) / Q_VAL);

  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic [CNT_W:0]       w_used;

  logic [LAT-1:0]       r_vld;
  logic [IF_W-1:0]      r_inflight;

  logic [K-1:0]         r_a0;
  logic [K-1:0]         r_b0;
  logic [K-1:0]         r_w0;
  logic [IDX_W-1:0]     r_idx0;

  logic [K:0]           w_sum1;
  logic [K:0]           w_sumMod;
  logic [K-1:0]         w_diff1;
  logic [K-1:0]         r_diff1;
  logic [K-1:0]         r_w1;

  logic [K-1:0]         r_sumDly [LAT-1];
  logic [IDX_W-1:0]     r_idxDly [LAT-1];

  logic [2*K-1:0]       r_prod2;
  logic [2*K+1:0]       w_mul3;
  logic [2*K+1:0]       r_mul3;
  logic [K+1:0]         r_x3;
  logic [K:0]           r_q4;
  logic [K+1:0]         r_x4;
  logic [K+1:0]         w_qq5;
  logic [K+1:0]         r_qq5;
  logic [K+1:0]         r_x5;
  logic [K+1:0]         r_r6;
  logic [K+1:0]         r_r7;
  logic [K-1:0]         r_red8;

  logic [K-1:0]         r_memA   [DEPTH];
  logic [K-1:0]         r_memB   [DEPTH];
  logic [IDX_W-1:0]     r_memIdx [DEPTH];
  logic [PTR_W-1:0]     r_wrPtr;
  logic [PTR_W-1:0]     r_rdPtr;
  logic [CNT_W-1:0]     r_count;

  // Credits: everything accepted but not yet retired must fit in the FIFO.
  assign w_used    = (CNT_W+1)'(r_inflight) + (CNT_W+1)'(r_count);
  assign in_ready  = rst_n & (w_used < (CNT_W+1)'(DEPTH));
  assign w_accept  = in_valid & in_ready;
  assign w_push    = r_vld[LAT-1];
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid & out_ready;

  assign out_a   = out_valid ? r_memA[r_rdPtr]   : '0;
  assign out_b   = out_valid ? r_memB[r_rdPtr]   : '0;
  assign out_idx = out_valid ? r_memIdx[r_rdPtr] : '0;

  // Modular add/sub: both operands are < Q so one conditional correction suffices;
  // the K-bit subtraction wraps, and adding Q back lands it in [0, Q).
  assign w_sum1   = {1'b0, r_a0} + {1'b0, r_b0};
  assign w_sumMod = (w_sum1 >= QK1) ? (w_sum1 - QK1) : w_sum1;
  assign w_diff1  = (r_a0 < r_b0) ? (r_a0 - r_b0 + QK) : (r_a0 - r_b0);

  // Barrett: quotient estimate from the top K+1 product bits times MU.
  assign w_mul3 = {{(K+1){1'b0}}, r_prod2[2*K-1:K-1]} * {{(K+1){1'b0}}, MU};
  // Remainder is known to be < 3Q < 2^(K+2), so only the low K+2 bits matter.
  assign w_qq5  = {1'b0, r_q4} * QK2;

  // Track which pipeline stages hold a live pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      r_vld <= {r_vld[LAT-2:0], w_accept};
    end
  end

  // Count pairs accepted but not yet written to the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else begin
      case ({w_accept, w_push})
        2'b10:   r_inflight <= r_inflight + IF_W'(1);
        2'b01:   r_inflight <= r_inflight - IF_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Arithmetic datapath; validity is carried separately in r_vld.
  always_ff @(posedge clk) begin
    r_a0    <= in_a;
    r_b0    <= in_b;
    r_w0    <= in_w;
    r_idx0  <= in_idx;

    r_diff1 <= w_diff1;
    r_w1    <= r_w0;
    r_sumDly[0] <= K'(w_sumMod);
    r_idxDly[0] <= r_idx0;
    for (int i = 1; i < LAT - 1; i++) begin
      r_sumDly[i] <= r_sumDly[i-1];
      r_idxDly[i] <= r_idxDly[i-1];
    end

    r_prod2 <= {{K{1'b0}}, r_diff1} * {{K{1'b0}}, r_w1};

    r_mul3  <= w_mul3;
    r_x3    <= r_prod2[K+1:0];
    r_q4    <= (K+1)'(r_mul3 >> (K+1));
    r_x4    <= r_x3;
    r_qq5   <= w_qq5;
    r_x5    <= r_x4;
    r_r6    <= r_x5 - r_qq5;
    r_r7    <= (r_r6 >= QK2) ? (r_r6 - QK2) : r_r6;
    r_red8  <= K'((r_r7 >= QK2) ? (r_r7 - QK2) : r_r7);
  end

  // FIFO storage, written when a result leaves the last pipeline stage.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memA[r_wrPtr]   <= r_sumDly[LAT-2];
      r_memB[r_wrPtr]   <= r_red8;
      r_memIdx[r_wrPtr] <= r_idxDly[LAT-2];
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
